// File: rtl/vga_timing_pkg.sv
// Shared 1280x800@60 timing constants, RGB555 layout and line-fill FSM encoding.
// Also used by the timing generator.
package vga_timing_pkg;

  localparam int H_ACTIVE = 1280;
  localparam int H_TOTAL  = 1680;
  localparam int V_ACTIVE = 800;
  localparam int V_TOTAL  = 828;
  localparam int ADDR_W   = 11;
  localparam int LINE_W   = 10;
  localparam int PIX_W    = 15;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } rgb555_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_DONE
  } fill_state_t;

endpackage

// File: rtl/line_ram.sv
// Two line banks of RGB555 words, simple dual-port, one-cycle synchronous read.
// Addresses are {bank, pixel}; no backpressure, contents are never cleared.
module line_ram
  import vga_timing_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] BANK_OFS = IDX_W'(H_ACTIVE);

  logic [PIX_W-1:0] mem [0:2*H_ACTIVE-1];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  // Banks are packed back to back, so bank 1 starts at H_ACTIVE rather than 2**ADDR_W.
  assign wr_idx = {1'b0, wr_addr[ADDR_W-1:0]} + (wr_addr[ADDR_W] ? BANK_OFS : '0);
  assign rd_idx = {1'b0, rd_addr[ADDR_W-1:0]} + (rd_addr[ADDR_W] ? BANK_OFS : '0);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/scanline_fetch.sv
// Double-buffered scanline stage: fills the back bank over req/ack + valid/ready, shows the front bank.
// Pixels and syncs leave one cycle after hpos; an unfinished fill at the swap point repeats the line.
module scanline_fetch
  import vga_timing_pkg::*;
(
  input  logic              pixel_clk,
  input  logic              rst_n,
  input  logic [14:0]       hpos,
  input  logic [14:0]       vpos,
  input  logic              blank_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic              fetch_req,
  output logic [LINE_W-1:0] fetch_line,
  input  logic              fetch_ack,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [14:0]       wr_data,
  output logic [4:0]        vr,
  output logic [4:0]        vg,
  output logic [4:0]        vb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam logic [14:0]       H_LAST       = 15'(H_TOTAL - 1);
  localparam logic [14:0]       H_ACT15      = 15'(H_ACTIVE);
  localparam logic [14:0]       V_LAST_FETCH = 15'(V_ACTIVE - 2);
  localparam logic [14:0]       V_LAST       = 15'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] WR_LAST      = ADDR_W'(H_ACTIVE - 1);

  fill_state_t       state, state_nxt;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
  logic [LINE_W-1:0] line_nxt;
  logic              sel, sel_nxt;
  logic              front_valid, front_valid_nxt;
  logic              underrun_set;
  logic              line_has_fetch, trig, swap;
  logic              wr_fire, last_word;
  logic              show;
  logic [PIX_W-1:0]  rd_data;
  rgb555_t           px;

  // The last blank line of the frame prefetches line 0; vblank lines otherwise stay quiet.
  assign line_has_fetch = (vpos <= V_LAST_FETCH) || (vpos == V_LAST);
  assign trig           = line_has_fetch && (hpos == '0);
  assign swap           = line_has_fetch && (hpos == H_LAST);

  assign fetch_req = (state == ST_REQ);
  assign wr_ready  = (state == ST_FILL);
  assign wr_fire   = wr_valid && wr_ready;
  assign last_word = wr_fire && (wr_addr == WR_LAST);

  always_comb begin
    state_nxt       = state;
    wr_addr_nxt     = wr_addr;
    line_nxt        = fetch_line;
    sel_nxt         = sel;
    front_valid_nxt = front_valid;
    underrun_set    = 1'b0;
    if (wr_fire) wr_addr_nxt = wr_addr + ADDR_W'(1);
    case (state)
      ST_IDLE: begin
        if (trig) begin
          state_nxt = ST_REQ;
          line_nxt  = (vpos == V_LAST) ? '0 : LINE_W'(vpos + 15'd1);
        end
      end
      ST_REQ: begin
        if (swap) begin
          state_nxt    = ST_IDLE;
          underrun_set = 1'b1;
        end else if (fetch_ack) begin
          state_nxt   = ST_FILL;
          wr_addr_nxt = '0;
        end
      end
      ST_FILL: begin
        // A last word landing on the swap cycle still counts as a complete line.
        if (swap) begin
          state_nxt = ST_IDLE;
          if (last_word) begin
            sel_nxt         = ~sel;
            front_valid_nxt = 1'b1;
          end else begin
            underrun_set = 1'b1;
          end
        end else if (last_word) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (swap) begin
          state_nxt       = ST_IDLE;
          sel_nxt         = ~sel;
          front_valid_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_addr     <= '0;
      fetch_line  <= '0;
      sel         <= 1'b0;
      front_valid <= 1'b0;
      underrun    <= 1'b0;
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b0;
      show        <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_addr     <= wr_addr_nxt;
      fetch_line  <= line_nxt;
      sel         <= sel_nxt;
      front_valid <= front_valid_nxt;
      underrun    <= underrun_set || (underrun && !underrun_clr);
      hsync_out   <= hsync_in;
      vsync_out   <= vsync_in;
      show        <= !blank_in && front_valid;
    end
  end

  line_ram u_line_ram (
    .clk     (pixel_clk),
    .wr_en   (wr_fire),
    .wr_addr ({~sel, wr_addr}),
    .wr_data (wr_data),
    .rd_en   (hpos < H_ACT15),
    .rd_addr ({sel, hpos[ADDR_W-1:0]}),
    .rd_data (rd_data)
  );

  // show is registered alongside the RAM read, so masking needs no extra pipeline stage.
  assign px = show ? rgb555_t'(rd_data) : '0;
  assign vr = px.r;
  assign vg = px.g;
  assign vb = px.b;

endmodule

// File: tb/tb_scanline_fetch.sv
// Directed bench for scanline_fetch: drives hpos/vpos itself (jumping between lines) and a req/ack source.
module tb_scanline_fetch;

  logic        pixel_clk, rst_n;
  logic [14:0] hpos, vpos;
  logic        blank_in, hsync_in, vsync_in;
  logic        fetch_req, fetch_ack, wr_valid, wr_ready;
  logic [9:0]  fetch_line;
  logic [14:0] wr_data;
  logic [4:0]  vr, vg, vb;
  logic        hsync_out, vsync_out, underrun, underrun_clr;

  int errors = 0;
  int checks = 0;

  int cur_h, cur_v;
  int src_en, src_limit, src_start_h, req_cnt, streaming, src_idx, src_line;
  int exp_line, pix_bad;

  typedef struct {
    int          h;
    logic        hs, vs, bl;
    logic        ehs, evs;
    logic [14:0] ergb;
  } vec_t;
  vec_t vecs [8];

  scanline_fetch dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
    .blank_in(blank_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .fetch_req(fetch_req), .fetch_line(fetch_line), .fetch_ack(fetch_ack),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .vr(vr), .vg(vg), .vb(vb), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Pixel i of source line L: low 11 bits carry i, top 4 bits carry L mod 16.
  function automatic logic [14:0] pix(input int line, input int i);
    int v;
    v = (line % 16) * 2048 + i;
    return v[14:0];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (vpos=%0d hpos=%0d)", name, act, exp, cur_v, cur_h);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_fetch_req"}, int'(fetch_req), 0);
    check({tag, "_fetch_line"}, int'(fetch_line), 0);
    check({tag, "_wr_ready"}, int'(wr_ready), 0);
    check({tag, "_rgb"}, int'({vr, vg, vb}), 0);
    check({tag, "_hsync_out"}, int'(hsync_out), 1);
    check({tag, "_vsync_out"}, int'(vsync_out), 0);
    check({tag, "_underrun"}, int'(underrun), 0);
  endtask

  // One pixel clock: drive timing and source, then score the RGB that belongs to the previous hpos.
  task automatic cycle();
    int   exp_fetch, was_h, exp_rgb;
    logic req_pre, fire, was_blank;
    exp_fetch = (cur_v == 827) ? 0 : cur_v + 1;
    hpos      = 15'(cur_h);
    vpos      = 15'(cur_v);
    blank_in  = (cur_h >= 1280) || (cur_v >= 800);
    hsync_in  = !(cur_h >= 1300 && cur_h < 1400);
    vsync_in  = (cur_v >= 801 && cur_v < 804);
    fetch_ack = (src_en != 0) && fetch_req && (req_cnt >= 1);
    wr_valid  = (streaming != 0) && (src_idx < src_limit) && (cur_h >= src_start_h);
    wr_data   = pix(src_line, src_idx);
    req_pre   = fetch_req;
    fire      = wr_valid && wr_ready;
    was_blank = blank_in;
    was_h     = cur_h;
    if (fetch_ack) check("fetch_line_at_ack", int'(fetch_line), exp_fetch);
    @(posedge pixel_clk);
    if (!rst_n) begin
      streaming = 0;
      req_cnt   = 0;
    end else begin
      req_cnt = req_pre ? req_cnt + 1 : 0;
      if (fetch_ack) begin
        streaming = 1;
        src_idx   = 0;
        src_line  = exp_fetch;
      end else if (fire) begin
        src_idx++;
      end
    end
    cur_h++;
    if (cur_h == 1680) begin
      cur_h = 0;
      cur_v = (cur_v == 827) ? 0 : cur_v + 1;
    end
    #1;
    exp_rgb = (was_blank || exp_line < 0) ? 0 : int'(pix(exp_line, was_h));
    if (int'({vr, vg, vb}) != exp_rgb) pix_bad++;
  endtask

  task automatic run_to(input int v, input int h);
    int n;
    n = 0;
    while (!(cur_v == v && cur_h == h) && n < 10000) begin
      cycle();
      n++;
    end
    check("run_to_reached", int'(cur_v == v && cur_h == h), 1);
  endtask

  task automatic run_line(input string name, input int exp);
    exp_line = exp;
    pix_bad  = 0;
    do cycle(); while (cur_h != 0);
    check(name, pix_bad, 0);
  endtask

  initial begin
    vecs[0] = '{5,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 15'h6005};
    vecs[1] = '{6,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 15'h6006};
    vecs[2] = '{7,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0000};
    vecs[3] = '{8,    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 15'h0000};
    vecs[4] = '{0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 15'h6000};
    vecs[5] = '{1279, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h64FF};
    vecs[6] = '{1278, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 15'h64FE};
    vecs[7] = '{31,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 15'h601F};

    src_en = 0; src_limit = 1280; src_start_h = 0; req_cnt = 0;
    streaming = 0; src_idx = 0; src_line = 0; exp_line = -1; pix_bad = 0;
    rst_n = 1'b0; hpos = '0; vpos = '0; blank_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b0;
    fetch_ack = 1'b0; wr_valid = 1'b0; wr_data = '0; underrun_clr = 1'b0;
    #12;
    check_reset_state("reset");
    rst_n = 1'b1;

    // No source: request for line 0 on the last frame line, then an underrun at its swap point.
    cur_v = 826; cur_h = 1600;
    run_to(827, 0);
    check("no_req_before_trigger", int'(fetch_req), 0);
    cycle();
    check("req_rise", int'(fetch_req), 1);
    check("req_line0", int'(fetch_line), 0);
    run_to(827, 1679);
    check("no_underrun_before_swap", int'(underrun), 0);
    underrun_clr = 1'b1;
    cycle();
    check("underrun_set_wins", int'(underrun), 1);
    check("abort_drops_req", int'(fetch_req), 0);
    src_en = 1;
    cycle();
    underrun_clr = 1'b0;
    check("underrun_clr", int'(underrun), 0);
    check("dark_without_source", pix_bad, 0);

    // Normal fills: line 1 fetched during line 0 and shown on line 1.
    run_line("line0_dark", -1);
    check("no_underrun_line0", int'(underrun), 0);
    run_line("line1_pixels", 1);

    // Stall after 1000 words while fetching line 6.
    cur_v = 4; cur_h = 0;
    run_line("line4_shows_line2", 2);
    src_limit = 1000;
    run_line("line5_pixels", 5);
    check("underrun_on_stall", int'(underrun), 1);
    check("abort_drops_ready", int'(wr_ready), 0);
    src_limit = 1280;
    run_line("line6_repeats_line5", 5);
    run_line("line7_pixels", 7);

    // Last word handshakes exactly on the swap cycle.
    cur_v = 10; cur_h = 0; exp_line = 8; pix_bad = 0;
    src_start_h = 400;
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    check("clear_before_late_fill", int'(underrun), 0);
    run_to(10, 1679);
    check("last_word_pending", int'(wr_ready), 1);
    cycle();
    check("late_last_no_underrun", int'(underrun), 0);
    check("late_last_ready_low", int'(wr_ready), 0);
    check("line10_shows_line8", pix_bad, 0);
    src_start_h = 0;
    run_line("line11_pixels", 11);

    // Sync/blank delay vectors in vblank, front bank holds line 12.
    for (int k = 0; k < 8; k++) begin
      hpos = 15'(vecs[k].h); vpos = 15'd810;
      hsync_in = vecs[k].hs; vsync_in = vecs[k].vs; blank_in = vecs[k].bl;
      fetch_ack = 1'b0; wr_valid = 1'b0;
      @(posedge pixel_clk);
      #1;
      check($sformatf("vec%0d_hsync", k), int'(hsync_out), int'(vecs[k].ehs));
      check($sformatf("vec%0d_vsync", k), int'(vsync_out), int'(vecs[k].evs));
      check($sformatf("vec%0d_rgb", k), int'({vr, vg, vb}), int'(vecs[k].ergb));
    end

    // Reset in the middle of the line-301 fill.
    cur_v = 300; cur_h = 0; exp_line = 12; pix_bad = 0;
    run_to(300, 200);
    check("line300_shows_line12", pix_bad, 0);
    hpos = 15'd200; vpos = 15'd300; blank_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b1;
    fetch_ack = 1'b0; wr_valid = 1'b1; wr_data = '0;
    @(posedge pixel_clk);
    #1;
    check("pre_reset_hsync", int'(hsync_out), 0);
    check("pre_reset_vsync", int'(vsync_out), 1);
    check("pre_reset_filling", int'(wr_ready), 1);
    check("pre_reset_rgb", int'({vr, vg, vb}), int'(pix(12, 200)));
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    cur_h = 201; exp_line = -1;
    repeat (3) cycle();
    rst_n = 1'b1;
    pix_bad = 0;
    run_to(301, 0);
    check("dark_after_reset", pix_bad, 0);
    check("no_underrun_after_reset", int'(underrun), 0);
    cur_v = 827; cur_h = 0;
    run_line("line827_dark", -1);
    run_line("frame_start_pixels", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
